// File: rtl/decode_pkg.sv
// Shared types for the decode stage: opcode/funct encodings, ALU op enum and
// the decoded entry carried through the output buffer.
package decode_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] imm;
        alu_op_e         alu_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            branch_ne;
        logic            jump;
        logic            use_imm;
        logic            illegal;
    } dec_entry_t;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake of the decode stage.
interface decode_if;
    import decode_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [RA_W-1:0] out_rs;
    logic [RA_W-1:0] out_rt;
    logic [RA_W-1:0] out_rd;
    logic [XLEN-1:0] out_imm;
    alu_op_e         out_alu_op;
    logic            out_reg_write;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_branch;
    logic            out_branch_ne;
    logic            out_jump;
    logic            out_use_imm;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_imm,
               out_alu_op, out_reg_write, out_mem_read, out_mem_write,
               out_branch, out_branch_ne, out_jump, out_use_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_imm,
               out_alu_op, out_reg_write, out_mem_read, out_mem_write,
               out_branch, out_branch_ne, out_jump, out_use_imm, out_illegal
    );

endinterface

// File: rtl/decode_logic.sv
// Combinational instruction decoder: instruction word + PC -> decoded entry.
module decode_logic
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output dec_entry_t      entry_c
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [XLEN-1:0] sext_imm;
    logic [XLEN-1:0] zext_imm;
    logic [XLEN-1:0] br_imm;
    logic [XLEN-1:0] j_imm;

    assign opcode   = instr_i[31:26];
    assign funct    = instr_i[5:0];
    assign sext_imm = {{16{instr_i[15]}}, instr_i[15:0]};
    assign zext_imm = {16'h0000, instr_i[15:0]};
    assign br_imm   = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    assign j_imm    = {pc_i[31:28], instr_i[25:0], 2'b00};

    always_comb begin
        entry_c    = '0;
        entry_c.pc = pc_i;
        entry_c.rs = instr_i[25:21];
        entry_c.rt = instr_i[20:16];
        entry_c.rd = instr_i[20:16];
        case (opcode)
            OP_RTYPE: begin
                entry_c.rd        = instr_i[15:11];
                entry_c.reg_write = 1'b1;
                case (funct)
                    FN_ADD: entry_c.alu_op = ALU_ADD;
                    FN_SUB: entry_c.alu_op = ALU_SUB;
                    FN_AND: entry_c.alu_op = ALU_AND;
                    FN_OR:  entry_c.alu_op = ALU_OR;
                    FN_SLT: entry_c.alu_op = ALU_SLT;
                    FN_SLL: begin
                        entry_c.alu_op  = ALU_SLL;
                        entry_c.imm     = XLEN'(instr_i[10:6]);
                        entry_c.use_imm = 1'b1;
                    end
                    default: begin
                        entry_c.reg_write = 1'b0;
                        entry_c.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
                entry_c.use_imm   = 1'b1;
                entry_c.reg_write = 1'b1;
                entry_c.mem_read  = (opcode == OP_LW);
                entry_c.imm       = (opcode == OP_ANDI || opcode == OP_ORI) ? zext_imm : sext_imm;
                entry_c.alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                                    (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
            end
            OP_SW: begin
                entry_c.alu_op    = ALU_ADD;
                entry_c.imm       = sext_imm;
                entry_c.use_imm   = 1'b1;
                entry_c.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                entry_c.alu_op    = ALU_SUB;
                entry_c.imm       = br_imm;
                entry_c.branch    = 1'b1;
                entry_c.branch_ne = (opcode == OP_BNE);
            end
            OP_J: begin
                entry_c.imm  = j_imm;
                entry_c.jump = 1'b1;
            end
            default: entry_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode feeding a BUF_DEPTH-entry FIFO so fetch
// can keep streaming while execute stalls.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    decode_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    dec_entry_t       mem_q [BUF_DEPTH];
    dec_entry_t       hold_q;
    dec_entry_t       dec_c;
    dec_entry_t       head_c;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_c;
    logic             pop_c;

    decode_logic u_decode_logic (
        .instr_i (bus.in_instr),
        .pc_i    (bus.in_pc),
        .entry_c (dec_c)
    );

    // Handshake depends only on the registered count, never on out_ready.
    assign bus.in_ready  = (count_q != CNT_W'(BUF_DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push_c        = bus.in_valid && bus.in_ready && !flush;
    assign pop_c         = bus.out_valid && bus.out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // hold_q tracks the visible head so outputs stay put once the buffer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_c)        mem_q[wr_ptr_q] <= dec_c;
            if (bus.out_valid) hold_q          <= mem_q[rd_ptr_q];
        end
    end

    assign head_c            = bus.out_valid ? mem_q[rd_ptr_q] : hold_q;
    assign bus.out_pc        = head_c.pc;
    assign bus.out_rs        = head_c.rs;
    assign bus.out_rt        = head_c.rt;
    assign bus.out_rd        = head_c.rd;
    assign bus.out_imm       = head_c.imm;
    assign bus.out_alu_op    = head_c.alu_op;
    assign bus.out_reg_write = head_c.reg_write;
    assign bus.out_mem_read  = head_c.mem_read;
    assign bus.out_mem_write = head_c.mem_write;
    assign bus.out_branch    = head_c.branch;
    assign bus.out_branch_ne = head_c.branch_ne;
    assign bus.out_jump      = head_c.jump;
    assign bus.out_use_imm   = head_c.use_imm;
    assign bus.out_illegal   = head_c.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios plus random streaming
// against a behavioural decode model.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    decode_if bus ();

    decode_stage #(.BUF_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    dec_entry_t exp_q[$];
    dec_entry_t pend;
    bit         pend_v = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    // Reference decode written straight from the opcode/funct table.
    function automatic dec_entry_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        dec_entry_t        e;
        logic [5:0]        op;
        logic [5:0]        fn;
        logic signed [15:0] s16;
        int                simm;
        op   = w[31:26];
        fn   = w[5:0];
        s16  = w[15:0];
        simm = s16;
        e    = '0;
        e.pc = pc;
        e.rs = w[25:21];
        e.rt = w[20:16];
        e.rd = (op == 6'h00) ? w[15:11] : w[20:16];
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: e.alu_op = ALU_ADD;
                    6'h22: e.alu_op = ALU_SUB;
                    6'h24: e.alu_op = ALU_AND;
                    6'h25: e.alu_op = ALU_OR;
                    6'h2A: e.alu_op = ALU_SLT;
                    6'h00: begin e.alu_op = ALU_SLL; e.imm = {27'd0, w[10:6]}; e.use_imm = 1'b1; end
                    default: e.illegal = 1'b1;
                endcase
                e.reg_write = !e.illegal;
            end
            6'h08: begin e.alu_op = ALU_ADD; e.imm = simm; e.use_imm = 1'b1; e.reg_write = 1'b1; end
            6'h0C: begin e.alu_op = ALU_AND; e.imm = {16'd0, w[15:0]}; e.use_imm = 1'b1; e.reg_write = 1'b1; end
            6'h0D: begin e.alu_op = ALU_OR;  e.imm = {16'd0, w[15:0]}; e.use_imm = 1'b1; e.reg_write = 1'b1; end
            6'h23: begin e.alu_op = ALU_ADD; e.imm = simm; e.use_imm = 1'b1; e.mem_read = 1'b1; e.reg_write = 1'b1; end
            6'h2B: begin e.alu_op = ALU_ADD; e.imm = simm; e.use_imm = 1'b1; e.mem_write = 1'b1; end
            6'h04, 6'h05: begin
                e.alu_op    = ALU_SUB;
                e.imm       = simm * 4;
                e.branch    = 1'b1;
                e.branch_ne = (op == 6'h05);
            end
            6'h02: begin e.jump = 1'b1; e.imm = (pc & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4); end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 14))
            0:  begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
            1:  begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
            2:  begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
            3:  begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
            4:  begin w[31:26] = 6'h00; w[5:0] = 6'h2A; end
            5:  begin w[31:26] = 6'h00; w[5:0] = 6'h00; end
            6:  w[31:26] = 6'h00;
            7:  w[31:26] = 6'h08;
            8:  w[31:26] = 6'h0C;
            9:  w[31:26] = 6'h0D;
            10: w[31:26] = 6'h23;
            11: w[31:26] = 6'h2B;
            12: w[31:26] = ($urandom_range(0, 1) != 0) ? 6'h05 : 6'h04;
            13: w[31:26] = 6'h02;
            default: ;
        endcase
        return w;
    endfunction

    always @(negedge rst_n) begin
        exp_q.delete();
        pend_v = 1'b0;
    end

    // Stimulus side of the scoreboard: an accepted word enters the model at the edge.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready && !flush) begin
            pend   = ref_decode(bus.in_instr, bus.in_pc);
            pend_v = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (pend_v) begin
            exp_q.push_back(pend);
            pend_v = 1'b0;
        end
    end

    // Monitor: handshake flags follow occupancy; each pop must match the model head.
    always @(negedge clk) begin
        dec_entry_t act;
        if (rst_n) begin
            chk1("out_valid", bus.out_valid, exp_q.size() != 0);
            chk1("in_ready", bus.in_ready, exp_q.size() != DEPTH);
            if (flush) begin
                exp_q.delete();
            end else if (bus.out_valid && bus.out_ready) begin
                act.pc        = bus.out_pc;
                act.rs        = bus.out_rs;
                act.rt        = bus.out_rt;
                act.rd        = bus.out_rd;
                act.imm       = bus.out_imm;
                act.alu_op    = bus.out_alu_op;
                act.reg_write = bus.out_reg_write;
                act.mem_read  = bus.out_mem_read;
                act.mem_write = bus.out_mem_write;
                act.branch    = bus.out_branch;
                act.branch_ne = bus.out_branch_ne;
                act.jump      = bus.out_jump;
                act.use_imm   = bus.out_use_imm;
                act.illegal   = bus.out_illegal;
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 128'(act), 128'(0));
                end else begin
                    chk("head_entry", 128'(act), 128'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // All tasks start and end at posedge+1.
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] p);
        bit acc = 1'b0;
        int n   = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        bus.in_pc    = p;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready && !flush;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk1("push_timeout", 1'b0, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_pc", 128'(bus.out_pc), 128'(0));
        chk("rst_out_imm", 128'(bus.out_imm), 128'(0));
        chk("rst_out_alu_op", 128'(bus.out_alu_op), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // add $3,$1,$2
        bus.out_ready = 1'b1;
        push(32'h0022_1820, 32'h0000_0100);
        chk1("add_valid", bus.out_valid, 1'b1);
        chk("add_rd", 128'(bus.out_rd), 128'(3));
        chk("add_alu", 128'(bus.out_alu_op), 128'(ALU_ADD));
        idle(2);

        // lw then beq
        push(32'h8CC5_FFFC, 32'h0000_0104);
        chk("lw_imm", 128'(bus.out_imm), 128'(32'hFFFF_FFFC));
        push(32'h1022_0003, 32'h0000_0108);
        chk("beq_imm", 128'(bus.out_imm), 128'(32'h0000_000C));
        idle(2);

        // back-pressure: third word waits for a free slot
        bus.out_ready = 1'b0;
        push(32'h0022_1820, 32'h0000_0200);
        push(32'h0043_2022, 32'h0000_0204);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h0064_2824;
        bus.in_pc    = 32'h0000_0208;
        idle(2);
        chk1("full_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        push(32'h0064_2824, 32'h0000_0208);
        idle(4);

        // flush with full buffer and concurrent push/pop
        bus.out_ready = 1'b0;
        push(32'h2021_0005, 32'h0000_0300);
        push(32'h3042_00FF, 32'h0000_0304);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0022_1820;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk1("flush_out_valid", bus.out_valid, 1'b0);
        chk1("flush_in_ready", bus.in_ready, 1'b1);
        idle(1);

        // illegal opcode flows through, stream continues
        push(32'hFC00_0000, 32'h0000_0400);
        chk1("illegal_flag", bus.out_illegal, 1'b1);
        push(32'h0800_1234, 32'h3000_0404);
        idle(3);

        // asynchronous reset with one entry buffered
        bus.out_ready = 1'b0;
        push(32'h0022_1820, 32'h0000_0500);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_out_valid", bus.out_valid, 1'b0);
        chk1("async_rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        push(32'h00A6_3822, 32'h0000_0600);
        idle(3);

        // randomized streaming with random back-pressure and rare flushes
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 79) == 0);
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_instr = rand_instr();
                bus.in_pc    = $urandom & 32'hFFFF_FFFC;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready && !flush;
            @(posedge clk); #1;
        end

        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        idle(6);
        chk("drain_empty", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
